pwm_capture: RTL and testbench

PWM measurement stage that sits directly downstream of the team's PWM generator. Samples an asynchronous PWM waveform, measures its high time and period in `clk` cycles, and delivers each completed measurement as one word on a valid/ready output port. Also flags a waveform stuck high or low (0 % / 100 % duty, or generator held in reset) through a timeout.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_sync_edge.sv | 48 ++++
 rtl/pwm_capture.sv | 171 +++++++++++++++++
 tb/tb_pwm_capture.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block and its generator.
package pwm_pkg;

  // Measurement FSM: waiting for a first rise, inside the high phase, inside the low phase.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } pwm_cap_state_t;

  // Default width of the high-time and period counters.
  localparam int unsigned CntWDefault = 16;

  // Nominal PWM period in clk cycles, common with the generator.
  localparam int unsigned PwmPeriod = 100;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, a history flop, and registered
// rise/fall pulses. Rise and fall see the same delay, so measured widths are exact.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next-state: shift the sample chain and decode edges from the synchronized pair.
  always_comb begin
    s1_d   = d_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period measurement with a valid/ready result port and a stuck-level
// timeout. Optional macro PWM_CAP_OVF_EN adds the ovf_cnt dropped-result counter port.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned MAX_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] per_cnt,
`ifdef PWM_CAP_OVF_EN
  output logic [7:0]       ovf_cnt,
`endif
  output logic             timeout,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PERIOD);

  logic lvl, rise, fall;

  pwm_sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d_in (pwm_in),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  pwm_cap_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic             m_valid_q, m_valid_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic             at_max;
  logic [CNT_W-1:0] cnt_inc;
  logic             res_vld;
  logic             load;

  assign at_max  = (cnt_q == MaxCnt);
  assign cnt_inc = at_max ? cnt_q : cnt_q + CNT_W'(1);

  // FSM next-state: a rise always beats a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    hi_d      = hi_q;
    res_vld   = 1'b0;
    timeout_d = 1'b0;
    stuck_d   = stuck_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = StHigh;
        end else if (at_max) begin
          timeout_d = 1'b1;
          stuck_d   = lvl;
          cnt_d     = CNT_W'(1);
        end
      end
      StHigh: begin
        if (fall) begin
          hi_d    = cnt_q;
          state_d = StLow;
        end else if (at_max) begin
          timeout_d = 1'b1;
          stuck_d   = lvl;
          cnt_d     = CNT_W'(1);
          state_d   = StIdle;
        end
      end
      StLow: begin
        // Closing rise of this period is the opening rise of the next one.
        if (rise) begin
          res_vld = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = StHigh;
        end else if (at_max) begin
          timeout_d = 1'b1;
          stuck_d   = lvl;
          cnt_d     = CNT_W'(1);
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output slot: load when empty or draining this cycle; otherwise the new result is lost.
  always_comb begin
    load      = res_vld & (~m_valid_q | m_ready);
    m_valid_d = m_valid_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    if (load) begin
      m_valid_d = 1'b1;
      hi_cnt_d  = hi_q;
      per_cnt_d = cnt_q;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Measurement and output state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
      m_valid_q <= 1'b0;
      hi_cnt_q  <= '0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
      m_valid_q <= m_valid_d;
      hi_cnt_q  <= hi_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

`ifdef PWM_CAP_OVF_EN
  logic       drop;
  logic [7:0] ovf_q, ovf_d;

  // Dropped-result counter, saturating; only reset clears it.
  always_comb begin
    drop  = res_vld & m_valid_q & ~m_ready;
    ovf_d = ovf_q;
    if (drop && (ovf_q != 8'hff)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // Dropped-result counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`endif

  assign m_valid   = m_valid_q;
  assign hi_cnt    = hi_cnt_q;
  assign per_cnt   = per_cnt_q;
  assign timeout   = timeout_q;
  assign stuck_lvl = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of PWM periods plus multi-cycle corner sequences.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CntW      = 16;
  localparam int MaxPeriod = 1000;
  localparam int NVec      = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pwm_in = 1'b0;
  logic            m_ready = 1'b0;
  logic            m_valid;
  logic [CntW-1:0] hi_cnt;
  logic [CntW-1:0] per_cnt;
  logic            timeout;
  logic            stuck_lvl;
`ifdef PWM_CAP_OVF_EN
  logic [7:0]      ovf_cnt;
`endif

  pwm_capture #(
    .CNT_W      (CntW),
    .MAX_PERIOD (MaxPeriod)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .hi_cnt    (hi_cnt),
    .per_cnt   (per_cnt),
`ifdef PWM_CAP_OVF_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .timeout   (timeout),
    .stuck_lvl (stuck_lvl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int res_hi[$];
  int res_per[$];
  int to_cycle[$];

  typedef struct {
    int hi;
    int lo;
    int exp_hi;
    int exp_per;
  } vec_t;

  vec_t vecs[NVec];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int h, input int l);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic clear_logs();
    res_hi.delete();
    res_per.delete();
    to_cycle.delete();
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    clear_logs();
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (res_hi.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer and timeout monitor; every accepted result must be a sane measurement.
  always @(negedge clk) begin
    if (rst) begin
      if (m_valid && m_ready) begin
        res_hi.push_back(int'(hi_cnt));
        res_per.push_back(int'(per_cnt));
        check("per_ge_2", int'(per_cnt >= 2), 1);
        check("hi_lt_per", int'(hi_cnt < per_cnt), 1);
      end
      if (timeout) to_cycle.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;

    vecs[0] = '{30, 70, 30, PwmPeriod};
    vecs[1] = '{5, 95, 5, PwmPeriod};
    vecs[2] = '{10, 90, 10, PwmPeriod};
    vecs[3] = '{15, 85, 15, PwmPeriod};
    vecs[4] = '{20, 80, 20, PwmPeriod};
    vecs[5] = '{25, 75, 25, PwmPeriod};
    vecs[6] = '{50, 50, 50, PwmPeriod};
    vecs[7] = '{95, 5, 95, PwmPeriod};
    vecs[8] = '{2, 2, 2, 4};
    vecs[9] = '{2, 998, 2, 1000};  // period equal to MAX_PERIOD: rise beats timeout

    // Reset values
    tick(2);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_hi_cnt", int'(hi_cnt), 0);
    check("rst_per_cnt", int'(per_cnt), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_stuck_lvl", int'(stuck_lvl), 0);
`ifdef PWM_CAP_OVF_EN
    check("rst_ovf_cnt", int'(ovf_cnt), 0);
`endif

    // Table of back-to-back periods, closed by one final rise
    m_ready = 1'b1;
    do_reset();
    for (int i = 0; i < NVec; i++) drive_period(vecs[i].hi, vecs[i].lo);
    pwm_in = 1'b1;
    wait_results(NVec, 20);
    check("table_count", res_hi.size(), NVec);
    for (int i = 0; i < NVec; i++) begin
      if (i < res_hi.size()) begin
        check($sformatf("table_hi[%0d]", i), res_hi[i], vecs[i].exp_hi);
        check($sformatf("table_per[%0d]", i), res_per[i], vecs[i].exp_per);
      end
    end
    check("table_no_timeout", to_cycle.size(), 0);

    // Latency: valid appears on the 3rd edge after the edge that samples the closing rise
    do_reset();
    drive_period(30, 70);
    pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_not_yet", int'(m_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", int'(m_valid), 1);
    check("lat_hi", int'(hi_cnt), 30);
    check("lat_per", int'(per_cnt), 100);
    tick(1);

    // Backpressure: first result held, next two dropped
    m_ready = 1'b0;
    do_reset();
    drive_period(30, 70);
    drive_period(40, 60);
    check("bp_hold_valid_a", int'(m_valid), 1);
    check("bp_hold_hi_a", int'(hi_cnt), 30);
    drive_period(50, 50);
    pwm_in = 1'b1;
    tick(5);
    check("bp_hold_valid_b", int'(m_valid), 1);
    check("bp_hold_hi_b", int'(hi_cnt), 30);
    check("bp_hold_per_b", int'(per_cnt), 100);
`ifdef PWM_CAP_OVF_EN
    check("bp_ovf_cnt", int'(ovf_cnt), 2);
`endif
    m_ready = 1'b1;
    tick(3);
    check("bp_count", res_hi.size(), 1);
    last = (res_hi.size() > 0) ? res_hi[0] : -1;
    check("bp_rel_hi", last, 30);
    last = (res_per.size() > 0) ? res_per[0] : -1;
    check("bp_rel_per", last, 100);
    check("bp_drained", int'(m_valid), 0);

    // Reset 40 cycles into a high phase with a result pending
    m_ready = 1'b0;
    do_reset();
    drive_period(30, 70);
    pwm_in = 1'b1;
    tick(40);
    check("mr_pending", int'(m_valid), 1);
    rst = 1'b0;
    #1;
    check("mr_m_valid", int'(m_valid), 0);
    check("mr_hi_cnt", int'(hi_cnt), 0);
    check("mr_per_cnt", int'(per_cnt), 0);
    check("mr_timeout", int'(timeout), 0);
`ifdef PWM_CAP_OVF_EN
    check("mr_ovf_cnt", int'(ovf_cnt), 0);
`endif
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b1;
    m_ready = 1'b1;
    tick(2);
    clear_logs();
    drive_period(30, 70);
    drive_period(30, 70);
    pwm_in = 1'b1;
    wait_results(2, 20);
    check("mr_count", res_hi.size(), 2);
    last = (res_hi.size() > 0) ? res_hi[0] : -1;
    check("mr_first_hi", last, 30);
    last = (res_per.size() > 0) ? res_per[0] : -1;
    check("mr_first_per", last, 100);

    // Stuck high: periodic timeout, no results
    do_reset();
    pwm_in = 1'b1;
    tick(3200);
    check("sh_pulses", to_cycle.size(), 3);
    for (int i = 1; i < to_cycle.size(); i++)
      check("sh_gap", to_cycle[i] - to_cycle[i-1], MaxPeriod);
    check("sh_stuck_lvl", int'(stuck_lvl), 1);
    check("sh_no_result", res_hi.size(), 0);
    check("sh_m_valid", int'(m_valid), 0);

    // Then stuck low without reset
    to_cycle.delete();
    pwm_in = 1'b0;
    tick(2100);
    check("sl_pulses", to_cycle.size(), 2);
    for (int i = 1; i < to_cycle.size(); i++)
      check("sl_gap", to_cycle[i] - to_cycle[i-1], MaxPeriod);
    check("sl_stuck_lvl", int'(stuck_lvl), 0);

    // Narrow pulses, then a normal period: no hang, sane results
    do_reset();
    drive_period(1, 1);
    drive_period(1, 1);
    drive_period(2, 2);
    drive_period(1, 3);
    drive_period(3, 1);
    drive_period(1, 2);
    drive_period(30, 70);
    pwm_in = 1'b1;
    tick(20);
    check("gl_some_results", int'(res_hi.size() >= 1), 1);
    last = (res_hi.size() > 0) ? res_hi[res_hi.size()-1] : -1;
    check("gl_last_hi", last, 30);
    last = (res_per.size() > 0) ? res_per[res_per.size()-1] : -1;
    check("gl_last_per", last, 100);
    check("gl_no_timeout", to_cycle.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
